// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parameterised UART receiver:
//   - uart_state_e : receiver FSM state encoding
//   - PAR_NONE / PAR_EVEN / PAR_ODD : values of the PARITY parameter
//   - calc_div()   : clocks per oversample tick,
//                    CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE) with integer divide
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // A divider below 1 would mean a tick faster than the clock; clamp it so
    // the tick simply fires every cycle in that degenerate case.
    function automatic int calc_div(input int clock_freq, input int baud_rate,
                                    input int oversample);
        int d;
        d = clock_freq / (baud_rate * oversample);
        if (d < 1) begin
            d = 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Free-running oversample tick generator. tick is a one-cycle pulse every
// DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE) clocks.
// Ports:
//   clk   in   system clock, rising edge
//   reset in   synchronous, active-low reset
//   tick  out  one-cycle sample tick
// ---------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        tick_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
// Parameterised UART receiver (DATA_BITS 5..9, none/even/odd parity,
// 1..2 stop bits) with an oversampled start/bit sampler.
//
// Optional feature: define UART_RX_MAJORITY_VOTE_EN to take each bit as the
// 2-of-3 majority of three consecutive ticks centred on mid-bit; otherwise a
// single sample at tick OVERSAMPLE/2-1 is used.
//
// Output handshake: rx_valid rises when a word is loaded and stays high until
// the cycle where rx_valid & rx_ready are both high (the word is consumed on
// that edge). A frame finishing while a word is still held and not being
// accepted is dropped and reported by a one-cycle overrun pulse.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-low reset
//   rx         in   asynchronous serial line, idle high
//   rx_data    out  received word (valid while rx_valid)
//   rx_valid   out  word available, held until accepted
//   rx_ready   in   consumer accepts on rx_valid & rx_ready
//   parity_err out  parity mismatch of the presented word
//   frame_err  out  a stop bit of the presented word sampled low
//   overrun    out  one-cycle pulse: completed frame dropped
//   busy       out  receiver not in IDLE
// ---------------------------------------------------------------------------
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW   = $clog2(OVERSAMPLE);
    localparam int BW   = $clog2(DATA_BITS + 1);
    localparam int HALF = OVERSAMPLE / 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
    // Decide after the third of the samples at HALF-1, HALF, HALF+1.
    localparam int START_LAST = HALF + 1;
`else
    localparam int START_LAST = HALF - 1;
`endif
    localparam logic [TW-1:0] START_LAST_C = TW'(START_LAST);
    localparam logic [TW-1:0] BIT_LAST_C   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST_C  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST_C  = BW'(STOP_BITS - 1);

    logic tick;

    uart_baud_tick #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // ---------------- synchronizer ----------------
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic rx_s;

    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
    end

    assign rx_s = sync2_q;

    // ---------------- bit value (single sample or vote) ----------------
    logic bit_val;

`ifdef UART_RX_MAJORITY_VOTE_EN
    // History of the two previous tick samples; at a decision tick these are
    // exactly the two earlier ticks of the three-sample window.
    logic [1:0] vote_q, vote_d;

    always_comb begin
        vote_d = vote_q;
        if (tick) begin
            vote_d = {vote_q[0], rx_s};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vote_q <= 2'b11;
        end else begin
            vote_q <= vote_d;
        end
    end

    assign bit_val = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s) | (vote_q[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    // ---------------- receive FSM ----------------
    uart_state_e          state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 frm_bad_q, frm_bad_d;
    logic                 frame_done;
    logic                 done_frm;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        frm_bad_d  = frm_bad_q;
        frame_done = 1'b0;
        done_frm   = frm_bad_q;

        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d    = ST_START;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        par_bad_d  = 1'b0;
                        frm_bad_d  = 1'b0;
                    end
                end

                ST_START: begin
                    if (tick_cnt_q == START_LAST_C) begin
                        tick_cnt_d = '0;
                        // A high line at mid start bit is a glitch, not a frame.
                        state_d    = bit_val ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (tick_cnt_q == BIT_LAST_C) begin
                        tick_cnt_d = '0;
                        shift_d    = {bit_val, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == DATA_LAST_C) begin
                            bit_cnt_d = '0;
                            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end

                ST_PARITY: begin
                    if (tick_cnt_q == BIT_LAST_C) begin
                        tick_cnt_d = '0;
                        // Even: data^bit must be 0; odd: data^bit must be 1.
                        par_bad_d  = ((^shift_q) ^ bit_val) != (PARITY == PAR_ODD);
                        state_d    = ST_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (tick_cnt_q == BIT_LAST_C) begin
                        tick_cnt_d = '0;
                        frm_bad_d  = frm_bad_q | ~bit_val;
                        if (bit_cnt_q == STOP_LAST_C) begin
                            frame_done = 1'b1;
                            done_frm   = frm_bad_q | ~bit_val;
                            bit_cnt_d  = '0;
                            // A low stop (e.g. a break) must see the line
                            // return high before a new start can be hunted.
                            state_d    = done_frm ? ST_WAIT_IDLE : ST_IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end

                ST_WAIT_IDLE: begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ---------------- output holding register ----------------
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 overrun_q, overrun_d;

    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        overrun_d  = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (frame_done) begin
            // The slot is free if empty or being emptied on this same edge.
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                par_err_d  = par_bad_q;
                frm_err_d  = done_frm;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            frm_bad_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_bad_q  <= par_bad_d;
            frm_bad_q  <= frm_bad_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = par_err_q;
    assign frame_err  = frm_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param
// Two receivers share clock and reset: dut_a is 8N1, dut_b is 7 data bits
// with odd parity, both at 50 MHz / 115200 baud / 16x (27 clocks per tick,
// 432 clocks per bit). Delivered words are compared against an expected
// queue per receiver; line-level corner cases are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_uart_rx_param;

    localparam int CLK_HZ   = 50_000_000;
    localparam int BAUD     = 115200;
    localparam int BIT_CLKS = 27 * 16;

    logic       clk;
    logic       reset_n;
    logic       rx_a, rx_b;
    logic       rx_ready_a, rx_ready_b;
    logic [7:0] rx_data_a;
    logic [6:0] rx_data_b;
    logic       rx_valid_a, rx_valid_b;
    logic       parity_err_a, parity_err_b;
    logic       frame_err_a, frame_err_b;
    logic       overrun_a, overrun_b;
    logic       busy_a, busy_b;

    uart_rx_param #(
        .CLOCK_FREQ (CLK_HZ),
        .BAUD_RATE  (BAUD),
        .OVERSAMPLE (16),
        .DATA_BITS  (8),
        .PARITY     (0),
        .STOP_BITS  (1)
    ) dut_a (
        .clk        (clk),
        .reset      (reset_n),
        .rx         (rx_a),
        .rx_data    (rx_data_a),
        .rx_valid   (rx_valid_a),
        .rx_ready   (rx_ready_a),
        .parity_err (parity_err_a),
        .frame_err  (frame_err_a),
        .overrun    (overrun_a),
        .busy       (busy_a)
    );

    uart_rx_param #(
        .CLOCK_FREQ (CLK_HZ),
        .BAUD_RATE  (BAUD),
        .OVERSAMPLE (16),
        .DATA_BITS  (7),
        .PARITY     (2),
        .STOP_BITS  (1)
    ) dut_b (
        .clk        (clk),
        .reset      (reset_n),
        .rx         (rx_b),
        .rx_data    (rx_data_b),
        .rx_valid   (rx_valid_b),
        .rx_ready   (rx_ready_b),
        .parity_err (parity_err_b),
        .frame_err  (frame_err_b),
        .overrun    (overrun_b),
        .busy       (busy_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters and scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int hs_a = 0;
    int hs_b = 0;
    int ovr_a = 0;
    int ovr_b = 0;

    // {frame_err, parity_err, data[8:0]}
    logic [10:0] exp_a_q[$];
    logic [10:0] exp_b_q[$];
    logic [10:0] exp_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_valid_a && rx_ready_a) begin
                hs_a++;
                if (exp_a_q.size() == 0) begin
                    check("unexpected_word_a", {24'd0, rx_data_a}, 32'hFFFF_FFFF);
                end else begin
                    exp_w = exp_a_q.pop_front();
                    check("word_a", {21'd0, frame_err_a, parity_err_a, 1'b0, rx_data_a}, {21'd0, exp_w});
                end
            end
            if (rx_valid_b && rx_ready_b) begin
                hs_b++;
                if (exp_b_q.size() == 0) begin
                    check("unexpected_word_b", {25'd0, rx_data_b}, 32'hFFFF_FFFF);
                end else begin
                    exp_w = exp_b_q.pop_front();
                    check("word_b", {21'd0, frame_err_b, parity_err_b, 2'b00, rx_data_b}, {21'd0, exp_w});
                end
            end
            if (overrun_a) ovr_a++;
            if (overrun_b) ovr_b++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit use_b, input logic v);
        if (use_b) rx_b = v;
        else       rx_a = v;
    endtask

    // Start, data LSB first, parity (dut_b only), one stop bit.
    // The line is left at the stop value.
    task automatic send_frame(input bit use_b, input logic [8:0] data,
                              input logic par_bit, input logic stop_bit);
        int nb;
        nb = use_b ? 7 : 8;
        set_line(use_b, 1'b0);
        wait_cycles(BIT_CLKS);
        for (int i = 0; i < nb; i++) begin
            set_line(use_b, data[i]);
            wait_cycles(BIT_CLKS);
        end
        if (use_b) begin
            set_line(use_b, par_bit);
            wait_cycles(BIT_CLKS);
        end
        set_line(use_b, stop_bit);
        wait_cycles(BIT_CLKS);
    endtask

    task automatic push_exp(input bit use_b, input logic [8:0] data,
                            input logic perr, input logic ferr);
        if (use_b) exp_b_q.push_back({ferr, perr, 2'b00, data[6:0]});
        else       exp_a_q.push_back({ferr, perr, 1'b0, data[7:0]});
    endtask

    // Bounded wait for all expected words to be delivered.
    task automatic drain(input string name);
        for (int k = 0; k < 2 * BIT_CLKS && (exp_a_q.size() != 0 || exp_b_q.size() != 0); k++) begin
            wait_cycles(1);
        end
        check(name, exp_a_q.size() + exp_b_q.size(), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         use_b;
        logic [8:0] data;
        logic       par_bit;
        logic       stop_bit;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int hs0;
        int ovr0;
        logic [7:0] d3c;

        // 8N1 words, then 7O1 words (odd parity: data^parity must be 1).
        vecs[0] = '{1'b0, 9'h0A5, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 9'h0FF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 9'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 9'h041, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 9'h041, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 9'h07F, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 9'h02A, 1'b0, 1'b0, 1'b0, 1'b1};

        rx_a       = 1'b1;
        rx_b       = 1'b1;
        rx_ready_a = 1'b1;
        rx_ready_b = 1'b1;
        reset_n    = 1'b0;
        wait_cycles(5);

        check("reset_valid_a", rx_valid_a, 0);
        check("reset_data_a", rx_data_a, 0);
        check("reset_flags_a", {parity_err_a, frame_err_a, overrun_a}, 0);
        check("reset_busy_a", busy_a, 0);
        check("reset_valid_b", rx_valid_b, 0);
        check("reset_busy_b", busy_b, 0);

        reset_n = 1'b1;
        wait_cycles(BIT_CLKS);

        // ---- table-driven frames ----
        for (int i = 0; i < NV; i++) begin
            hs0 = vecs[i].use_b ? hs_b : hs_a;
            push_exp(vecs[i].use_b, vecs[i].data, vecs[i].exp_perr, vecs[i].exp_ferr);
            send_frame(vecs[i].use_b, vecs[i].data, vecs[i].par_bit, vecs[i].stop_bit);
            set_line(vecs[i].use_b, 1'b1);
            wait_cycles(BIT_CLKS);
            drain($sformatf("vec%0d_drain", i));
            check($sformatf("vec%0d_count", i), (vecs[i].use_b ? hs_b : hs_a) - hs0, 1);
        end

        // ---- false start: 4 ticks low ----
        hs0 = hs_a;
        rx_a = 1'b0;
        wait_cycles(60);
        check("glitch_busy_high", busy_a, 1);
        wait_cycles(4 * 27 - 60);
        rx_a = 1'b1;
        wait_cycles(3 * BIT_CLKS);
        check("glitch_busy_low", busy_a, 0);
        check("glitch_no_word", hs_a - hs0, 0);

        // ---- break: stop bit low then line held low 20 bit times ----
        hs0 = hs_a;
        push_exp(1'b0, 9'h055, 1'b0, 1'b1);
        send_frame(1'b0, 9'h055, 1'b0, 1'b0);
        wait_cycles(10 * BIT_CLKS);
        check("break_busy_mid", busy_a, 1);
        wait_cycles(10 * BIT_CLKS);
        check("break_busy_end", busy_a, 1);
        rx_a = 1'b1;
        wait_cycles(BIT_CLKS);
        check("break_busy_released", busy_a, 0);
        drain("break_drain");
        check("break_count", hs_a - hs0, 1);

        // ---- overrun: two frames while not ready ----
        rx_ready_a = 1'b0;
        hs0  = hs_a;
        ovr0 = ovr_a;
        push_exp(1'b0, 9'h011, 1'b0, 1'b0);
        send_frame(1'b0, 9'h011, 1'b0, 1'b1);
        wait_cycles(BIT_CLKS);
        check("ovr_first_valid", rx_valid_a, 1);
        send_frame(1'b0, 9'h022, 1'b0, 1'b1);
        wait_cycles(BIT_CLKS);
        check("ovr_pulses", ovr_a - ovr0, 1);
        check("ovr_held_valid", rx_valid_a, 1);
        check("ovr_held_data", rx_data_a, 8'h11);
        check("ovr_no_accept", hs_a - hs0, 0);
        rx_ready_a = 1'b1;
        wait_cycles(2);
        check("ovr_valid_cleared", rx_valid_a, 0);
        check("ovr_accept_count", hs_a - hs0, 1);
        check("ovr_drain", exp_a_q.size(), 0);

        // ---- reset during data bit 4 of 0x3C, then 0x96 ----
        hs0 = hs_a;
        d3c = 8'h3C;
        rx_a = 1'b0;
        wait_cycles(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx_a = d3c[i];
            wait_cycles(BIT_CLKS);
        end
        rx_a = d3c[4];
        wait_cycles(BIT_CLKS / 2);
        reset_n = 1'b0;
        wait_cycles(3);
        check("midreset_busy", busy_a, 0);
        check("midreset_valid", rx_valid_a, 0);
        reset_n = 1'b1;
        rx_a = 1'b1;
        wait_cycles(2 * BIT_CLKS);
        check("midreset_idle", busy_a, 0);
        push_exp(1'b0, 9'h096, 1'b0, 1'b0);
        send_frame(1'b0, 9'h096, 1'b0, 1'b1);
        wait_cycles(BIT_CLKS);
        drain("midreset_drain");
        check("midreset_count", hs_a - hs0, 1);
        check("midreset_overrun", ovr_a - ovr0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
